// File: rtl/usb_tx_line_encoder.sv
// USB full-speed transmit line encoder: SYNC prefix, bit stuffing, NRZI and EOP
// generation driving D+/D- from a byte-wide valid/ready stream.
module usb_tx_line_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus_out,
    output logic       d_minus_out,
    output logic       tx_active,
    output logic       tx_error
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0_1,
        EOP_SE0_2,
        EOP_J
    } state_t;

    state_t           state;
    state_t           resume_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       ones_cnt;
    logic [7:0]       shifter;
    logic             cur_last;
    logic [7:0]       hold_data;
    logic             hold_last;
    logic             hold_full;
    logic             last_accepted;

    logic   bit_end;
    logic   accept;
    logic   in_stream;
    state_t mode;
    logic   do_stuff;
    logic   sync_done;
    logic   byte_done;
    logic   next_bit;

    assign bit_end   = (bit_cnt == BIT_END);
    assign in_stream = (state == IDLE) || (state == SYNC) || (state == DATA) || (state == STUFF);
    assign tx_ready  = !hold_full && !last_accepted && in_stream;
    assign accept    = tx_valid && tx_ready;

    // A stuff bit resumes whatever state it interrupted, so decisions use that state.
    always_comb begin
        mode      = (state == STUFF) ? resume_state : state;
        do_stuff  = (state != STUFF) && (ones_cnt == 3'd6);
        sync_done = (mode == SYNC) && (bit_idx == 3'd7);
        byte_done = (mode == DATA) && (bit_idx == 3'd7);
        next_bit  = 1'b0;
        if (do_stuff) begin
            next_bit = 1'b0;
        end else if (mode == SYNC) begin
            next_bit = sync_done ? hold_data[0] : (bit_idx == 3'd6);
        end else if (mode == DATA) begin
            next_bit = byte_done ? hold_data[0] : shifter[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            resume_state  <= SYNC;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            ones_cnt      <= '0;
            shifter       <= '0;
            cur_last      <= 1'b0;
            hold_data     <= '0;
            hold_last     <= 1'b0;
            hold_full     <= 1'b0;
            last_accepted <= 1'b0;
            d_plus_out    <= 1'b1;
            d_minus_out   <= 1'b0;
            tx_active     <= 1'b0;
            tx_error      <= 1'b0;
        end else begin
            tx_error <= 1'b0;

            if (accept) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
                hold_full <= 1'b1;
                if (tx_last) begin
                    last_accepted <= 1'b1;
                end
            end

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        // First SYNC bit is a 0, so the line toggles from idle J to K.
                        state       <= SYNC;
                        bit_idx     <= '0;
                        ones_cnt    <= '0;
                        tx_active   <= 1'b1;
                        d_plus_out  <= 1'b0;
                        d_minus_out <= 1'b1;
                    end
                end

                SYNC, DATA, STUFF: begin
                    if (bit_end) begin
                        if (do_stuff) begin
                            state        <= STUFF;
                            resume_state <= state;
                            ones_cnt     <= '0;
                            d_plus_out   <= ~d_plus_out;
                            d_minus_out  <= ~d_minus_out;
                        end else if (byte_done && !hold_full) begin
                            tx_error    <= !cur_last;
                            state       <= EOP_SE0_1;
                            d_plus_out  <= 1'b0;
                            d_minus_out <= 1'b0;
                        end else begin
                            if (next_bit) begin
                                ones_cnt <= ones_cnt + 1'b1;
                            end else begin
                                ones_cnt    <= '0;
                                d_plus_out  <= ~d_plus_out;
                                d_minus_out <= ~d_minus_out;
                            end
                            if (sync_done || byte_done) begin
                                state     <= DATA;
                                shifter   <= hold_data;
                                cur_last  <= hold_last;
                                hold_full <= 1'b0;
                                bit_idx   <= '0;
                            end else begin
                                state   <= mode;
                                bit_idx <= bit_idx + 1'b1;
                                if (mode == DATA) begin
                                    shifter <= shifter >> 1;
                                end
                            end
                        end
                    end
                end

                EOP_SE0_1: begin
                    if (bit_end) begin
                        state <= EOP_SE0_2;
                    end
                end

                EOP_SE0_2: begin
                    if (bit_end) begin
                        state       <= EOP_J;
                        d_plus_out  <= 1'b1;
                        d_minus_out <= 1'b0;
                    end
                end

                EOP_J: begin
                    if (bit_end) begin
                        state         <= IDLE;
                        tx_active     <= 1'b0;
                        last_accepted <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed bench for usb_tx_line_encoder: table of packets with hand-derived
// line sequences, plus reset and latency sequences.
module tb_usb_tx_line_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       d_plus_out;
    logic       d_minus_out;
    logic       tx_active;
    logic       tx_error;

    int compared;
    int mismatched;

    typedef struct {
        logic [23:0] bytes;
        int          nbytes;
        bit          last_flag;
        string       line;
        int          active_cycles;
        int          errors;
    } vec_t;

    vec_t vecs [4];

    usb_tx_line_encoder #(.CLKS_PER_BIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .d_plus_out  (d_plus_out),
        .d_minus_out (d_minus_out),
        .tx_active   (tx_active),
        .tx_error    (tx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lineSym(input logic dp, input logic dm);
        case ({dp, dm})
            2'b10:   return "J";
            2'b01:   return "K";
            2'b00:   return "0";
            default: return "X";
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, " d+"}, 32'(d_plus_out), 32'd1);
        checkOutput({name, " d-"}, 32'(d_minus_out), 32'd0);
        checkOutput({name, " active"}, 32'(tx_active), 32'd0);
        checkOutput({name, " ready"}, 32'(tx_ready), 32'd1);
        checkOutput({name, " error"}, 32'(tx_error), 32'd0);
    endtask

    // Called on a negedge; drives bytes and watches the line until tx_active falls.
    task automatic applyStimulus(input int v);
        int active_cnt;
        int err_cnt;
        active_cnt = 0;
        err_cnt    = 0;
        fork
            begin
                for (int i = 0; i < vecs[v].nbytes; i++) begin
                    bit got;
                    got      = 1'b0;
                    tx_data  = vecs[v].bytes[8*i +: 8];
                    tx_last  = (i == vecs[v].nbytes - 1) && vecs[v].last_flag;
                    tx_valid = 1'b1;
                    for (int w = 0; w < 2000 && !got; w++) begin
                        got = tx_ready;
                        @(negedge clk);
                    end
                    if (!got) begin
                        checkOutput($sformatf("v%0d byte%0d accept timeout", v, i), 32'd0, 32'd1);
                    end
                end
                tx_valid = 1'b0;
                tx_last  = 1'b0;
            end
            begin
                for (int w = 0; w < 50 && !tx_active; w++) begin
                    @(negedge clk);
                end
                while (tx_active && active_cnt < 2000) begin
                    if ((active_cnt % 8) == 4 && (active_cnt / 8) < vecs[v].line.len()) begin
                        checkOutput($sformatf("v%0d bit%0d line", v, active_cnt / 8),
                                    32'(lineSym(d_plus_out, d_minus_out)),
                                    32'(vecs[v].line[active_cnt / 8]));
                    end
                    if (tx_error) begin
                        err_cnt++;
                    end
                    active_cnt++;
                    @(negedge clk);
                end
            end
        join
        checkOutput($sformatf("v%0d active cycles", v), 32'(active_cnt), 32'(vecs[v].active_cycles));
        checkOutput($sformatf("v%0d error pulses", v), 32'(err_cnt), 32'(vecs[v].errors));
        checkIdle($sformatf("v%0d after packet", v));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bad;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        tx_last    = 1'b0;

        vecs[0] = '{bytes: 24'h000000, nbytes: 1, last_flag: 1'b1,
                    line: "KJKJKJKKJKJKJKJK00J", active_cycles: 152, errors: 0};
        vecs[1] = '{bytes: 24'h0000FF, nbytes: 1, last_flag: 1'b1,
                    line: "KJKJKJKKKKKKKJJJJ00J", active_cycles: 160, errors: 0};
        vecs[2] = '{bytes: 24'h813CA5, nbytes: 3, last_flag: 1'b1,
                    line: "KJKJKJKKKJJKJJKKJKKKKKJKKJKJKJKK00J", active_cycles: 280, errors: 0};
        vecs[3] = '{bytes: 24'h000012, nbytes: 1, last_flag: 1'b0,
                    line: "KJKJKJKKJJKJJKJK00J", active_cycles: 152, errors: 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkIdle("reset");

        for (int v = 0; v < 4; v++) begin
            applyStimulus(v);
            repeat (3) @(negedge clk);
        end

        // Mid-packet reset: first bit must appear one cycle after accept, and reset aborts with no EOP.
        tx_data  = 8'h00;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first bit latency active", 32'(tx_active), 32'd1);
        checkOutput("first bit latency line", 32'(lineSym(d_plus_out, d_minus_out)), 32'("K"));
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        checkOutput("ready low while holding", 32'(tx_ready), 32'd0);
        repeat (90) @(negedge clk);
        checkOutput("pre-reset data bit 3", 32'(lineSym(d_plus_out, d_minus_out)), 32'("K"));
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkIdle("mid-packet reset");
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tx_active || !d_plus_out || d_minus_out) begin
                bad++;
            end
        end
        checkOutput("no EOP after reset", 32'(bad), 32'd0);
        applyStimulus(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/usb_tx_line_encoder.md
Name: usb_tx_line_encoder

Overview:
Transmit-side USB full-speed line encoder, the TX counterpart of the RX EOP/NRZI path. Accepts packet bytes over a valid/ready handshake and prepends SYNC. Applies bit stuffing and NRZI encoding, and drives D+/D- with an EOP (SE0, SE0, J) after the last byte. Sits between the TX packet FIFO/controller and the USB pad drivers.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit time (96 MHz / 12 Mbps); legal range >= 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
tx_data  input  8  packet byte, transmitted LSB first
tx_valid  input  1  tx_data/tx_last valid
tx_last  input  1  marks the final byte of the packet; qualified by tx_valid
tx_ready  output  1  block can accept a byte this cycle
d_plus_out  output  1  D+ line drive
d_minus_out  output  1  D- line drive
tx_active  output  1  pad output enable; high from the first SYNC bit through the end of the EOP J bit
tx_error  output  1  one-cycle pulse on underrun

Behaviour:
- Line states: J = (d_plus_out=1, d_minus_out=0); K = (0,1); SE0 = (0,0). The idle line is J.
- Reset (sync, rst=1 at a posedge): all state and outputs go idle at that edge.
  - d_plus_out=1, d_minus_out=0, tx_active=0, tx_error=0, tx_ready=1.
  - Holding register is cleared.
  - Reset mid-packet aborts immediately with no EOP.
- Buffering: one 8-bit shift register plus one holding register (byte + last flag).
  - tx_ready = holding empty AND no last byte yet accepted for the current packet.
  - A byte is accepted on a cycle with tx_valid && tx_ready.
- Bit timer: counter 0..CLKS_PER_BIT-1. Each line bit is held exactly CLKS_PER_BIT cycles. All outputs are registered.
- FSM states: IDLE, SYNC, DATA, STUFF, EOP_SE0_1, EOP_SE0_2, EOP_J.
  - IDLE: accepting a byte at cycle T loads the holding register and enters SYNC. At T+1, tx_active=1 and the first SYNC bit is on the line.
  - SYNC: sends 8 bits 0000_0001 (LSB first), giving line K J K J K J K K. At the end, the holding register moves to the shifter, the holding register frees (tx_ready may rise), and the FSM enters DATA.
  - DATA: shifts out 8 bits LSB first. At the byte boundary:
    - if the holding register is full, load it with no gap;
    - else if the current byte was last, go to EOP_SE0_1;
    - else (underrun), pulse tx_error for 1 cycle and go to EOP_SE0_1.
  - STUFF: after six consecutive 1 bits, insert one 0 bit and return to the interrupted state/bit position.
    - The ones counter includes SYNC's final 1.
    - It resets on any 0 bit, including stuff bits.
    - A stuff bit due after the final data bit is sent before EOP.
  - EOP_SE0_1, EOP_SE0_2: SE0, 1 bit time each.
  - EOP_J: J for 1 bit time. Then IDLE, and tx_active drops on the next cycle.
- NRZI: a 0 bit toggles J/K; a 1 bit holds the previous state. The reference level at packet start is idle J. The EOP is not NRZI/stuff processed.
- tx_valid asserted in IDLE with tx_last=1 gives a one-byte packet.
- tx_valid while tx_ready=0 is ignored (no accept). The byte must be held by the source.
- Bytes arriving during EOP are not accepted until IDLE.

Test Plan:
1. Hold rst=1 for 2 cycles, then release -> d_plus_out=1, d_minus_out=0, tx_active=0, tx_ready=1, tx_error=0.
2. Send one byte 0x00 with tx_last=1 -> line K J K J K J K K, then J K J K J K J K, then SE0 SE0 J, each 8 cycles; tx_active high for exactly 152 cycles.
3. Send one byte 0xFF with tx_last=1 -> SYNC, then five held-K bits, a stuff toggle to J, three held-J bits, then EOP; tx_active high for exactly 160 cycles.
4. Send three bytes 0xA5, 0x3C, 0x81 (last) with tx_valid held high -> no inter-byte gap; tx_ready accepts byte 2 at the end of SYNC and byte 3 at the end of byte 1; 32 bits + EOP; tx_error stays 0.
5. Send byte 0x12 with tx_last=0, then keep tx_valid=0 -> tx_error pulses for 1 cycle at the end of byte 1, then SE0 SE0 J; tx_active drops; tx_ready=1.
6. Assert rst during the 4th data bit of a packet -> at that edge the line is J, tx_active=0, and no EOP follows; a new one-byte packet afterwards is sent correctly.
